// File: rtl/pfixed_to_pfloat.sv
// Signed fixed point (FRAC_BITS fractional bits) to IEEE-754 single, one normalizing shift per clock.
// Latency: ACK_FX rises leading-zeros+1 clocks after Begin; no backpressure, the result is held in DONE until RST_FSM_FX.
module pfixed_to_pfloat #(
    parameter int FRAC_BITS = 26
) (
    input  logic        CLK,
    input  logic        RST_FF,
    input  logic        RST_FSM_FX,
    input  logic        Begin_FSM_FX,
    input  logic [31:0] X,
    output logic        ACK_FX,
    output logic [31:0] RESULT
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    // Exponent of the input LSB position once bit 31 is the hidden one.
    localparam logic [7:0] EXP_INIT = 8'(127 + 31 - FRAC_BITS);

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic        zero_q, zero_d;
    logic [31:0] mag_q, mag_d;
    logic [7:0]  exp_q, exp_d;
    logic        ack_q, ack_d;
    logic [31:0] result_q, result_d;

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        ack_d    = ack_q;
        result_d = result_q;
        if (RST_FSM_FX) begin
            state_d = IDLE;
            ack_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Begin_FSM_FX) begin
                        sign_d  = X[31];
                        // Negating 32'h8000_0000 wraps to itself, which is the correct magnitude.
                        mag_d   = X[31] ? (~X + 32'd1) : X;
                        exp_d   = EXP_INIT;
                        zero_d  = (X == 32'd0);
                        state_d = NORM;
                    end
                end
                NORM: begin
                    if (zero_q) begin
                        result_d = 32'h0000_0000;
                        ack_d    = 1'b1;
                        state_d  = DONE;
                    end else if (mag_q[31]) begin
                        result_d = {sign_q, exp_q, mag_q[30:8]};
                        ack_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        mag_d = {mag_q[30:0], 1'b0};
                        exp_d = exp_q - 8'd1;
                    end
                end
                DONE: begin
                    ack_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_FF) begin
        if (!RST_FF) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            mag_q    <= 32'd0;
            exp_q    <= 8'd0;
            ack_q    <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            ack_q    <= ack_d;
            result_q <= result_d;
        end
    end

    assign ACK_FX = ack_q;
    assign RESULT = result_q;
endmodule

// File: tb/tb_pfixed_to_pfloat.sv
// Scoreboard bench for pfixed_to_pfloat with FRAC_BITS=26.
module tb_pfixed_to_pfloat;
    localparam int FRAC = 26;

    logic        CLK = 1'b0;
    logic        RST_FF = 1'b0;
    logic        RST_FSM_FX = 1'b0;
    logic        Begin_FSM_FX = 1'b0;
    logic [31:0] X = 32'd0;
    logic        ACK_FX;
    logic [31:0] RESULT;

    typedef struct {
        logic [31:0] res;
        int          lat;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    pfixed_to_pfloat #(.FRAC_BITS(FRAC)) dut (
        .CLK(CLK),
        .RST_FF(RST_FF),
        .RST_FSM_FX(RST_FSM_FX),
        .Begin_FSM_FX(Begin_FSM_FX),
        .X(X),
        .ACK_FX(ACK_FX),
        .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Independent reference: find the leading one by scanning down from bit 31.
    function automatic exp_t ref_conv(input logic [31:0] x, input string tag);
        exp_t        e;
        logic [31:0] m;
        int          lz;
        int          ex;
        e.tag = tag;
        m = x[31] ? (32'd0 - x) : x;
        if (x == 32'd0) begin
            e.res = 32'd0;
            e.lat = 1;
        end else begin
            lz = 0;
            for (int b = 31; b >= 0; b--) begin
                if (m[b]) break;
                lz++;
            end
            ex = 127 + 31 - FRAC - lz;
            m = m << lz;
            e.res = {x[31], 8'(ex), m[30:8]};
            e.lat = lz + 1;
        end
        return e;
    endfunction

    task automatic push_const(input logic [31:0] res, input int lat, input string tag);
        exp_t e;
        e.res = res;
        e.lat = lat;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Clears back to IDLE, launches one conversion and compares against the queue head.
    task automatic run_conv(input logic [31:0] x);
        exp_t e;
        int   n;
        RST_FSM_FX = 1'b1;
        tick();
        RST_FSM_FX = 1'b0;
        X = x;
        Begin_FSM_FX = 1'b1;
        tick();
        Begin_FSM_FX = 1'b0;
        X = $urandom;
        n = 0;
        while (!ACK_FX && n < 40) begin
            tick();
            n++;
        end
        e = exp_q.pop_front();
        if (!ACK_FX) chk({e.tag, "_timeout"}, 32'(ACK_FX), 32'd1);
        chk({e.tag, "_res"}, RESULT, e.res);
        chk({e.tag, "_lat"}, 32'(n), 32'(e.lat));
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] rx;

        X = 32'h3D00_0000;
        Begin_FSM_FX = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_ack", 32'(ACK_FX), 32'd0);
            chk("rst_res", RESULT, 32'd0);
        end
        Begin_FSM_FX = 1'b0;
        RST_FF = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_ack", 32'(ACK_FX), 32'd0);

        push_const(32'h3F80_0000, 6, "one");
        run_conv(32'h0400_0000);
        push_const(32'hBF80_0000, 6, "mone");
        run_conv(32'hFC00_0000);
        push_const(32'hC174_0000, 3, "m15_25");
        run_conv(32'hC300_0000);
        push_const(32'h4174_0000, 3, "p15_25");
        run_conv(32'h3D00_0000);
        push_const(32'h0000_0000, 1, "zero");
        run_conv(32'h0000_0000);
        push_const(32'hC200_0000, 1, "minneg");
        run_conv(32'h8000_0000);
        push_const(32'h3280_0000, 32, "lsb");
        run_conv(32'h0000_0001);
        push_const(32'h3F99_9999, 6, "trunc");
        run_conv(32'h04CC_CCCD);

        for (int i = 0; i < 8; i++) begin
            rx = $urandom >> $urandom_range(0, 31);
            if (i[0]) rx = 32'd0 - rx;
            exp_q.push_back(ref_conv(rx, "rand"));
            run_conv(rx);
        end

        // Begin held in DONE must not disturb the held result.
        prev = RESULT;
        X = 32'h1234_5678;
        Begin_FSM_FX = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        Begin_FSM_FX = 1'b0;
        chk("done_ack", 32'(ACK_FX), 32'd1);
        chk("done_res", RESULT, prev);

        // Abort a long conversion in NORM.
        RST_FSM_FX = 1'b1;
        tick();
        RST_FSM_FX = 1'b0;
        X = 32'h0000_0001;
        Begin_FSM_FX = 1'b1;
        tick();
        Begin_FSM_FX = 1'b0;
        tick();
        RST_FSM_FX = 1'b1;
        tick();
        RST_FSM_FX = 1'b0;
        begin
            int rises = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (ACK_FX) rises++;
            end
            chk("abort_ack", 32'(rises), 32'd0);
        end
        chk("abort_res", RESULT, prev);

        push_const(32'h3F80_0000, 6, "after_abort");
        run_conv(32'h0400_0000);

        // Begin held across the clear starts on the first IDLE edge.
        RST_FSM_FX = 1'b1;
        X = 32'hC300_0000;
        Begin_FSM_FX = 1'b1;
        tick();
        RST_FSM_FX = 1'b0;
        tick();
        Begin_FSM_FX = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("held_begin", RESULT, 32'hC174_0000);

        // Async reset mid-conversion clears the result at once.
        RST_FSM_FX = 1'b1;
        tick();
        RST_FSM_FX = 1'b0;
        X = 32'h0000_0001;
        Begin_FSM_FX = 1'b1;
        tick();
        Begin_FSM_FX = 1'b0;
        tick();
        #2;
        RST_FF = 1'b0;
        #1;
        chk("arst_res", RESULT, 32'd0);
        chk("arst_ack", 32'(ACK_FX), 32'd0);
        RST_FF = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
